// File: rtl/lm70_pkg.sv
// lm70_pkg: shared types and constants for the LM70/LM07 SPI sampler.
//   lm70_state_e   - sampler FSM states
//   Lm70LsbMilliC  - weight of one temperature LSB (0.25 C) in milli-degrees
//   Lm70FrameBits  - default SCK cycles per CS-low frame
//   Lm70DataBits   - default width of the signed temperature field
//   sign_extend()  - sign-extend the low 'width' bits of a 32-bit word
package lm70_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StUpdate,
    StWait
  } lm70_state_e;

  localparam int unsigned Lm70LsbMilliC = 250;
  localparam int unsigned Lm70FrameBits = 16;
  localparam int unsigned Lm70DataBits  = 11;

  // width must be in 1..31; bit width-1 is the sign bit.
  function automatic logic [31:0] sign_extend(input logic [31:0] value,
                                              input int unsigned width);
    logic [31:0] upper;
    logic [4:0]  msb;
    upper = 32'hFFFF_FFFF << width;
    msb   = 5'(width - 1);
    return value[msb] ? (value | upper) : (value & ~upper);
  endfunction

endpackage

// File: rtl/lm70_sck_gen.sv
// lm70_sck_gen: SCK divider for the LM70 sampler.
// While en is high, produces FRAME_BITS SCK periods, each CLK_DIV clk cycles low followed by
// CLK_DIV cycles high. Everything is held cleared while en is low.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - run the divider (high only while the FSM is shifting)
//   sck        - registered serial clock, idles low
//   rise       - strobe: the coming clk edge drives sck high (capture point)
//   done       - strobe: the coming clk edge ends the last high half of the frame
//   bit_cnt    - index of the SCK period in progress (advances at each SCK fall)
module lm70_sck_gen #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  output logic                              sck,
  output logic                              rise,
  output logic                              done,
  output logic [$clog2(FRAME_BITS+1)-1:0]   bit_cnt
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FRAME_BITS - 1);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic            sck_q, sck_d;
  logic            half_end;

  assign half_end = en && (div_cnt_q == DivLast);
  assign rise     = half_end && !sck_q;
  assign done     = half_end && sck_q && (bit_cnt_q == BitLast);
  assign sck      = sck_q;
  assign bit_cnt  = bit_cnt_q;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    if (!en) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      sck_d     = 1'b0;
    end else if (half_end) begin
      div_cnt_d = '0;
      sck_d     = ~sck_q;
      if (sck_q) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
    end
  end

endmodule

// File: rtl/lm70_spi_sampler.sv
// lm70_spi_sampler: SPI master for LM07/LM70-family temperature sensors.
// Runs single-shot (start) or periodic (cont_en) conversions, captures the signed DATA_BITS
// temperature field from the head of each FRAME_BITS frame, box-car averages 2^AVG_LOG2 samples
// and publishes the result on a valid/ready interface.
// Optional build macro LM70_SPI_SAMPLER_ALARM_EN adds a hysteresis over-temperature alarm.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - single-shot request (IDLE only); cont_en - continuous mode enable
//   cs_n, sck    - sensor chip select (active low) and serial clock (idles low)
//   sio          - sensor serial data
//   temp_data    - signed averaged temperature, LSB = 0.25 C
//   temp_valid   - temp_data valid; temp_ready - consumer accepts temp_data
//   overrun      - one-cycle pulse when an unaccepted result is overwritten
//   busy         - FSM not in IDLE
//   thr_hi/thr_lo/alarm (macro only) - alarm set above thr_hi, cleared below thr_lo
module lm70_spi_sampler
  import lm70_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FRAME_BITS = Lm70FrameBits,
  parameter int unsigned DATA_BITS  = Lm70DataBits,
  parameter int unsigned AVG_LOG2   = 0,
  parameter int unsigned PERIOD     = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        cont_en,
  output logic                        cs_n,
  output logic                        sck,
  input  logic                        sio,
  output logic [DATA_BITS-1:0]        temp_data,
  output logic                        temp_valid,
  input  logic                        temp_ready,
  output logic                        overrun,
  output logic                        busy
`ifdef LM70_SPI_SAMPLER_ALARM_EN
  ,
  input  logic signed [DATA_BITS-1:0] thr_hi,
  input  logic signed [DATA_BITS-1:0] thr_lo,
  output logic                        alarm
`endif
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);
  localparam int unsigned AccW = DATA_BITS + AVG_LOG2;
  localparam int unsigned CntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntLast  = CntW'((1 << AVG_LOG2) - 1);
  localparam logic [BitW-1:0] DataBits = BitW'(DATA_BITS);
  localparam logic [31:0]     PerLast  = 32'(PERIOD - 1);

  lm70_state_e           state_q, state_d;
  logic                  launch_q, launch_d;
  logic [DivW-1:0]       ph_cnt_q, ph_cnt_d;
  logic [31:0]           per_cnt_q, per_cnt_d;
  logic                  cs_n_q, cs_n_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic [DATA_BITS:0]    shift_ext;
  logic [AccW-1:0]       acc_q, acc_d;
  logic [AccW-1:0]       sum, avg;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  publish;
  logic                  sck_rise, sck_done;
  logic [BitW-1:0]       bit_cnt;

  lm70_sck_gen #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_sck_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q == StShift),
    .sck     (sck),
    .rise    (sck_rise),
    .done    (sck_done),
    .bit_cnt (bit_cnt)
  );

  // Requests are registered for one cycle in IDLE so that cs_n falls on the edge after start
  // is sampled.
  always_comb begin
    state_d  = state_q;
    launch_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch_q) begin
          state_d = StSetup;
        end else begin
          launch_d = start || cont_en;
        end
      end
      StSetup:  if (ph_cnt_q == DivLast) state_d = StShift;
      StShift:  if (sck_done) state_d = StHold;
      StHold:   if (ph_cnt_q == DivLast) state_d = StUpdate;
      StUpdate: state_d = cont_en ? StWait : StIdle;
      StWait: begin
        if (!cont_en) begin
          state_d = StIdle;
        end else if (per_cnt_q >= PerLast) begin
          state_d = StSetup;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ph_cnt_d = ph_cnt_q + 1'b1;
    if ((state_d != state_q) || !(state_q inside {StSetup, StHold})) begin
      ph_cnt_d = '0;
    end
    // Period counter restarts on every SETUP entry and saturates while waiting.
    per_cnt_d = per_cnt_q;
    if ((state_d == StSetup) && (state_q != StSetup)) begin
      per_cnt_d = '0;
    end else if ((state_q != StIdle) && (per_cnt_q < PerLast)) begin
      per_cnt_d = per_cnt_q + 32'd1;
    end
    cs_n_d = !(state_d inside {StSetup, StShift});
  end

  // Only the first DATA_BITS captured bits are kept; the tail of the frame is discarded.
  assign shift_ext = {shreg_q, sio};
  assign sum       = acc_q + AccW'(sign_extend(32'(shreg_q), DATA_BITS));
  assign avg       = AccW'($signed(sum) >>> AVG_LOG2);
  assign publish   = (state_q == StUpdate) && (cnt_q == CntLast);

  always_comb begin
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if ((state_q == StShift) && sck_rise && (bit_cnt < DataBits)) begin
      shreg_d = shift_ext[DATA_BITS-1:0];
    end
    if (valid_q && temp_ready) begin
      valid_d = 1'b0;
    end
    if (publish) begin
      acc_d     = '0;
      cnt_d     = '0;
      data_d    = avg[DATA_BITS-1:0];
      valid_d   = 1'b1;
      overrun_d = valid_q && !temp_ready;
    end else if (state_q == StUpdate) begin
      acc_d = sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      launch_q  <= 1'b0;
      ph_cnt_q  <= '0;
      per_cnt_q <= '0;
      cs_n_q    <= 1'b1;
      shreg_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      launch_q  <= launch_d;
      ph_cnt_q  <= ph_cnt_d;
      per_cnt_q <= per_cnt_d;
      cs_n_q    <= cs_n_d;
      shreg_q   <= shreg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign temp_data  = data_q;
  assign temp_valid = valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

`ifdef LM70_SPI_SAMPLER_ALARM_EN
  logic alarm_q, alarm_d;

  // Hysteresis: values inside [thr_lo, thr_hi] leave the alarm unchanged.
  always_comb begin
    alarm_d = alarm_q;
    if (publish) begin
      if ($signed(data_d) > thr_hi) begin
        alarm_d = 1'b1;
      end else if ($signed(data_d) < thr_lo) begin
        alarm_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  // Alarm comparator not built.
`endif

endmodule
